// File: rtl/counter_mod.sv
// counter_mod: modulo-MODULUS up/down counter with synchronous clear and load,
// count enable, terminal-count flag, registered wrap pulse and a registered
// one-hot decode of the count.
// Optional build macro COUNTER_MOD_SAT_EN: when defined, the counter
// saturates at its terminal count instead of wrapping around.
module counter_mod #(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               sclr,
  input  logic               enable,
  input  logic               up,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  output logic [WIDTH-1:0]   state,
  output logic [MODULUS-1:0] state_onehot,
  output logic               tc,
  output logic               wrap
);

  // Highest legal count, held at WIDTH bits so every compare is WIDTH wide.
  // Using "> MAX_VAL" rather than ">= MODULUS" keeps the clamp correct when
  // MODULUS == 2**WIDTH (MODULUS itself is not representable in WIDTH bits).
  localparam logic [WIDTH-1:0]   MAX_VAL    = WIDTH'(MODULUS - 1);
  localparam logic [MODULUS-1:0] ONEHOT_RST = MODULUS'(1);

  logic [WIDTH-1:0]   state_reg;
  logic [WIDTH-1:0]   state_next;
  logic [MODULUS-1:0] onehot_reg;
  logic [MODULUS-1:0] onehot_next;
  logic               wrap_reg;
  logic               wrap_next;
  logic               at_max;
  logic               at_zero;
  logic               tc_int;

  assign at_max  = (state_reg == MAX_VAL);
  assign at_zero = (state_reg == '0);
  assign tc_int  = up ? at_max : at_zero;

  // Next count and wrap pulse; priority is sclr > load > enable > hold.
  always_comb begin
    state_next = state_reg;
    wrap_next  = 1'b0;
    if (sclr) begin
      state_next = '0;
    end else if (load) begin
      state_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (enable) begin
`ifdef COUNTER_MOD_SAT_EN
      // Saturating: stop at the terminal count, never pulse wrap.
      if (!tc_int) begin
        state_next = up ? (state_reg + WIDTH'(1)) : (state_reg - WIDTH'(1));
      end
`else
      if (up) begin
        if (at_max) begin
          state_next = '0;
          wrap_next  = 1'b1;
        end else begin
          state_next = state_reg + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          state_next = MAX_VAL;
          wrap_next  = 1'b1;
        end else begin
          state_next = state_reg - WIDTH'(1);
        end
      end
`endif
    end
  end

  // Decode the next count so the one-hot register updates on the same edge
  // as the binary count, with no decode lag on the timing-state lines.
  generate
    for (genvar gi = 0; gi < MODULUS; gi++) begin : g_onehot
      assign onehot_next[gi] = (state_next == WIDTH'(gi));
    end
  endgenerate

  // Count, one-hot and wrap registers; clear_n discards any pending wrap.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_reg  <= '0;
      onehot_reg <= ONEHOT_RST;
      wrap_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      onehot_reg <= onehot_next;
      wrap_reg   <= wrap_next;
    end
  end

  assign state        = state_reg;
  assign state_onehot = onehot_reg;
  assign wrap         = wrap_reg;
  assign tc           = tc_int;

endmodule

// File: tb/tb_counter_mod.sv
// Testbench for counter_mod (WIDTH=3, MODULUS=6): directed scenarios with
// literal expectations plus randomized stimulus, all compared every cycle
// against a behavioural model of the counting rules.
module tb_counter_mod;

  localparam int W = 3;
  localparam int M = 6;

  logic         clock;
  logic         clear_n;
  logic         sclr;
  logic         enable;
  logic         up;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] state;
  logic [M-1:0] state_onehot;
  logic         tc;
  logic         wrap;

  int pass_count  = 0;
  int total_count = 0;
  bit check_en    = 0;

  // behavioural model state
  int m_state = 0;
  int m_wrap  = 0;

  counter_mod #(.WIDTH(W), .MODULUS(M)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .sclr        (sclr),
    .enable      (enable),
    .up          (up),
    .load        (load),
    .load_value  (load_value),
    .state       (state),
    .state_onehot(state_onehot),
    .tc          (tc),
    .wrap        (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    total_count++;
    if (actual == expected) pass_count++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Model: the counting rules written as modular arithmetic.
  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_state <= 0;
      m_wrap  <= 0;
    end else if (sclr) begin
      m_state <= 0;
      m_wrap  <= 0;
    end else if (load) begin
      m_state <= (int'(load_value) > M - 1) ? M - 1 : int'(load_value);
      m_wrap  <= 0;
    end else if (enable) begin
`ifdef COUNTER_MOD_SAT_EN
      if (up) m_state <= (m_state == M - 1) ? m_state : m_state + 1;
      else    m_state <= (m_state == 0) ? 0 : m_state - 1;
      m_wrap <= 0;
`else
      if (up) begin
        m_state <= (m_state + 1) % M;
        m_wrap  <= (m_state == M - 1) ? 1 : 0;
      end else begin
        m_state <= (m_state + M - 1) % M;
        m_wrap  <= (m_state == 0) ? 1 : 0;
      end
`endif
    end else begin
      m_wrap <= 0;
    end
  end

  // Compare every cycle, mid-period, against the model.
  always @(negedge clock) begin
    if (check_en) begin
      check("state", int'(state), m_state);
      check("onehot", int'(state_onehot), 1 << m_state);
      check("wrap", int'(wrap), m_wrap);
      check("tc", int'(tc), (up ? (m_state == M - 1) : (m_state == 0)) ? 1 : 0);
    end
  end

  // Apply current inputs at the next rising edge, return 2 ns after it.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_in(input bit s, input bit ld, input int lv, input bit en, input bit u);
    sclr       = s;
    load       = ld;
    load_value = W'(lv);
    enable     = en;
    up         = u;
  endtask

  initial begin
    clear_n = 1'b0;
    set_in(0, 0, 0, 1, 1);
    step();
    step();
    check_en = 1;
    // reset values
    check("rst_state", int'(state), 0);
    check("rst_onehot", int'(state_onehot), 1);
    check("rst_tc_up", int'(tc), 0);
    up = 0;
    #1;
    check("rst_tc_dn", int'(tc), 1);
    up = 1;
    clear_n = 1'b1;
    step();
    step();
    step();
    check("pre_async_state", int'(state), 3);
    step();
    // asynchronous reset mid-clock, held 15 ns
    #1 clear_n = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_onehot", int'(state_onehot), 6'b000001);
    #14 clear_n = 1'b1;
    step();
    check("rel_1", int'(state), 1);
    step();
    check("rel_2", int'(state), 2);
    step();
    check("rel_3", int'(state), 3);

`ifndef COUNTER_MOD_SAT_EN
    // up wrap 0..5,0
    set_in(1, 0, 0, 0, 1);
    step();
    check("sclr_zero", int'(state), 0);
    set_in(0, 0, 0, 1, 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      check("upseq", int'(state), i % 6);
      if (i == 5) check("up_tc5", int'(tc), 1);
      check("up_wrap", int'(wrap), (i == 6) ? 1 : 0);
    end
    // down wrap from 2: 1,0,5,4
    set_in(0, 1, 2, 0, 0);
    step();
    check("load2", int'(state), 2);
    set_in(0, 0, 0, 1, 0);
    step();
    check("dn1", int'(state), 1);
    step();
    check("dn0", int'(state), 0);
    check("dn_tc0", int'(tc), 1);
    step();
    check("dn5", int'(state), 5);
    check("dn_wrap5", int'(wrap), 1);
    step();
    check("dn4", int'(state), 4);
    check("dn_wrap4", int'(wrap), 0);
`else
    // saturating up: 8 enabled cycles from 0 stop at 5
    set_in(1, 0, 0, 0, 1);
    step();
    set_in(0, 0, 0, 1, 1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("sat_up", int'(state), (i > 5) ? 5 : i);
      check("sat_wrap", int'(wrap), 0);
    end
    up = 0;
    step();
    check("sat_dn4", int'(state), 4);
    step();
    check("sat_dn3", int'(state), 3);
    step();
    check("sat_dn2", int'(state), 2);
`endif

    // load and clamp
    set_in(0, 1, 3, 0, 1);
    step();
    check("load3", int'(state), 3);
    set_in(0, 1, 7, 0, 1);
    step();
    check("clamp7", int'(state), 5);
    set_in(0, 1, 2, 1, 1);
    step();
    check("load_vs_wrap", int'(state), 2);
    check("load_wrap0", int'(wrap), 0);
    // priority and hold
    set_in(1, 1, 4, 1, 1);
    step();
    check("sclr_over_load", int'(state), 0);
    set_in(0, 1, 4, 0, 1);
    step();
    set_in(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold", int'(state), 4);
      check("hold_wrap", int'(wrap), 0);
    end
    // reset during count at 4
    enable = 1;
    #1 clear_n = 1'b0;
    #1;
    check("rst_at4", int'(state), 0);
    step();
    clear_n = 1'b1;
    step();

    // randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 4) != 0) ? up : ~up);
      clear_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step();
    end
    clear_n = 1'b1;
    step();
    check_en = 0;

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo-N up/down counter with synchronous load, enable, synchronous clear, terminal-count flag, wrap pulse and one-hot state decode. It is the general replacement for the fixed 2-bit state counter in the CPU control path. The one-hot output drives the controller's timing-state lines T0..T(N-1) directly. The binary output also serves as a generic loop or step counter elsewhere in the datapath.

## Interface
- WIDTH, 2, bit width of the binary count.
- MODULUS, 4, number of states; count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH.
- clock  in  1  rising-edge clock.
- clear_n  in  1  asynchronous, active-low reset.
- sclr  in  1  synchronous clear to 0.
- enable  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load.
- state  out  WIDTH  current count, registered.
- state_onehot  out  MODULUS  one-hot decode of state; bit i high iff state == i.
- tc  out  1  terminal count, combinational from state and up.
- wrap  out  1  registered pulse marking a wrap-around.

## Operation
- Reset values (clear_n low): state = 0, state_onehot = 1 (bit 0 set), wrap = 0. tc = 0 if up = 1, tc = 1 if up = 0.
- Per-edge priority: clear_n > sclr > load > enable > hold.
- sclr = 1: state <= 0, wrap <= 0.
- load = 1: state <= load_value. If load_value >= MODULUS, state <= MODULUS-1 (clamp). wrap <= 0. enable is ignored in that cycle.
- enable = 1, up = 1: state <= state+1. If state == MODULUS-1, state <= 0 and wrap <= 1.
- enable = 1, up = 0: state <= state-1. If state == 0, state <= MODULUS-1 and wrap <= 1.
- enable = 0: state holds; wrap <= 0.
- tc = (up && state == MODULUS-1) || (!up && state == 0). tc is not gated by enable.
- Direction may change on any cycle. The next step uses the up value sampled at that edge.
- state never leaves 0..MODULUS-1 under any input sequence.
- Width rules:
  - All compares are done at WIDTH bits.
  - When MODULUS == 2**WIDTH, natural overflow and wrap coincide, and the logic stays correct.

## Timing
- Latency: one clock from any control input to state. state_onehot is registered alongside state, so it changes on the same edge with no decode lag.
- wrap is high for exactly the one cycle in which state holds the post-wrap value. Continuous counting at MODULUS = 4 gives wrap = 1 every 4th cycle.
- clear_n assertion takes effect immediately and asynchronously. Release is synchronous in effect: the first count occurs on the first rising edge with clear_n high.
- Reset mid-count discards the count and any pending wrap.
- load and wrap in the same cycle: load wins and wrap = 0.

## Configuration
- COUNTER_MOD_SAT_EN:
  - Defined: saturating mode. With enable = 1 and tc = 1, state holds at MODULUS-1 (counting up) or 0 (counting down), and wrap stays 0.
  - Not defined: wrap-around behaviour as specified above.
  - sclr, load, clamping and tc are identical in both builds.

## Test plan
All scenarios use WIDTH = 3, MODULUS = 6.
- Reset: clear_n = 0 for 15 ns mid-clock -> state = 0 and state_onehot = 6'b000001 immediately. After release with enable = 1, up = 1, state steps 1, 2, 3 on successive edges.
- Up wrap: enable = 1, up = 1 from 0 -> state sequence 0, 1, 2, 3, 4, 5, 0. tc = 1 while state = 5. wrap = 1 only in the cycle where state = 0.
- Down wrap: enable = 1, up = 0 from 2 -> sequence 2, 1, 0, 5, 4. tc = 1 at state = 0. wrap = 1 in the cycle where state = 5.
- Load and clamp:
  - load = 1, load_value = 3 -> state = 3 next cycle.
  - load_value = 7 -> state = 5.
  - load with enable = 1 at state 5, up = 1 -> state = load_value and wrap = 0.
- Priority and hold:
  - sclr = 1 together with load = 1 -> state = 0.
  - enable = 0 for 3 cycles -> state unchanged and wrap = 0.
  - clear_n = 0 during a count at state 4 -> state = 0 at once.
- With COUNTER_MOD_SAT_EN defined: up-count from 0 for 8 enabled cycles -> state stops at 5 with wrap never high. Switching to up = 0 then counts 4, 3, 2.
